// File: rtl/cpu_state_sequencer.sv
// Multicycle FETCH/LOAD/MEM/EXEC/HALT sequencer for the bus-based MIPS core.
// Owns the instruction register, the load-data latch and the retired-instruction counter.
module cpu_state_sequencer #(
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
    parameter int          COUNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               waitrequest,
    input  logic [31:0]        readdata,
    input  logic [31:0]        pc_next,
    input  logic               multdiv_busy,
    output logic [2:0]         state,
    output logic [31:0]        instr,
    output logic [31:0]        mem_data,
    output logic               ir_write_en,
    output logic               pc_write_en,
    output logic               active,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_LOAD  = 3'd1,
        S_MEM   = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        mem_data_q, mem_data_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [5:0] opcode;
    logic       is_load;
    logic       mem_op;

    assign opcode  = instr_q[31:26];
    assign is_load = (opcode >= 6'd32) && (opcode <= 6'd38);
    assign mem_op  = is_load || (opcode == 6'd40) || (opcode == 6'd41) || (opcode == 6'd43);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            instr_q    <= '0;
            mem_data_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            mem_data_q <= mem_data_d;
            count_q    <= count_d;
        end
    end

    // Strobes are only raised on the cycle a stage actually completes, so a
    // stalled FETCH or EXEC never produces a partial capture or PC update.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        mem_data_d  = mem_data_q;
        count_d     = count_q;
        ir_write_en = 1'b0;
        pc_write_en = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!waitrequest) begin
                    ir_write_en = 1'b1;
                    instr_d     = readdata;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_MEM;
            end
            S_MEM: begin
                if (!(mem_op && waitrequest)) begin
                    if (is_load) begin
                        mem_data_d = readdata;
                    end
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!multdiv_busy) begin
                    pc_write_en = 1'b1;
                    count_d     = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                    state_d     = (pc_next == HALT_ADDR) ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign state       = state_q;
    assign instr       = instr_q;
    assign mem_data    = mem_data_q;
    assign instr_count = count_q;
    assign active      = (state_q != S_HALT);

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Scoreboard bench for cpu_state_sequencer: per-cycle and per-retire expectations
// come from an instruction-level timing model and are checked by an independent monitor.
module tb_cpu_state_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          waitrequest = 1'b0;
    logic [31:0]   readdata = 32'h0;
    logic [31:0]   pc_next = 32'h0;
    logic          multdiv_busy = 1'b0;
    logic [2:0]    state;
    logic [31:0]   instr;
    logic [31:0]   mem_data;
    logic          ir_write_en;
    logic          pc_write_en;
    logic          active;
    logic [CW-1:0] instr_count;

    cpu_state_sequencer #(.HALT_ADDR(32'h0000_0000), .COUNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .waitrequest(waitrequest),
        .readdata(readdata),
        .pc_next(pc_next),
        .multdiv_busy(multdiv_busy),
        .state(state),
        .instr(instr),
        .mem_data(mem_data),
        .ir_write_en(ir_write_en),
        .pc_write_en(pc_write_en),
        .active(active),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] st;
        logic       irw;
        logic       pcw;
        logic       act;
    } cyc_exp_t;

    typedef struct {
        int            at;
        logic [31:0]   ins;
        logic [31:0]   md;
        logic [CW-1:0] cnt;
    } ret_exp_t;

    cyc_exp_t cq[$];
    ret_exp_t rq[$];

    logic [31:0]   m_mem;
    logic [CW-1:0] m_cnt;
    logic [31:0]   m_instr;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic bit is_load_op(input logic [5:0] op);
        return (op >= 6'd32) && (op <= 6'd38);
    endfunction

    function automatic bit is_mem_op(input logic [5:0] op);
        return is_load_op(op) || op == 6'd40 || op == 6'd41 || op == 6'd43;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drive(input logic wr, input logic [31:0] rd, input logic busy,
                         input logic [31:0] pcn, input logic [2:0] st,
                         input logic irw, input logic pcw, input logic act);
        cyc_exp_t e;
        waitrequest  = wr;
        readdata     = rd;
        multdiv_busy = busy;
        pc_next      = pcn;
        e.st = st; e.irw = irw; e.pcw = pcw; e.act = act;
        cq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One instruction: fw fetch stalls, mw memory stalls, bc mult/div busy cycles.
    task automatic apply_stimulus(input logic [31:0] ins, input int fw, input int mw,
                                  input int bc, input logic [31:0] ld, input logic [31:0] pcn);
        logic [5:0] op;
        bit         mem;
        int         lat;
        ret_exp_t   r;
        op  = ins[31:26];
        mem = is_mem_op(op);
        lat = 4 + fw + (mem ? mw : 0) + bc;
        if (is_load_op(op)) m_mem = ld;
        m_instr = ins;
        r.at = cyc + lat - 1; r.ins = ins; r.md = m_mem; r.cnt = m_cnt;
        rq.push_back(r);
        m_cnt = m_cnt + 1'b1;
        for (int i = 0; i < fw; i++)
            drive(1'b1, $urandom, rbit(), $urandom, 3'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, ins, rbit(), $urandom, 3'd0, 1'b1, 1'b0, 1'b1);
        drive(rbit(), $urandom, rbit(), $urandom, 3'd1, 1'b0, 1'b0, 1'b1);
        if (mem) begin
            for (int i = 0; i < mw; i++)
                drive(1'b1, $urandom, rbit(), $urandom, 3'd2, 1'b0, 1'b0, 1'b1);
            drive(1'b0, ld, rbit(), $urandom, 3'd2, 1'b0, 1'b0, 1'b1);
        end else begin
            drive(rbit(), ld, rbit(), $urandom, 3'd2, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < bc; i++)
            drive(rbit(), $urandom, 1'b1, rbit() ? 32'h0 : $urandom, 3'd3, 1'b0, 1'b0, 1'b1);
        drive(rbit(), $urandom, 1'b0, pcn, 3'd3, 1'b0, 1'b1, 1'b1);
    endtask

    // Monitor: compares every expected cycle and every PC-write retire event.
    always @(negedge clk) begin
        cyc_exp_t e;
        ret_exp_t r;
        if (cq.size() > 0) begin
            e = cq.pop_front();
            check_output("state", 32'(state), 32'(e.st));
            check_output("ir_write_en", 32'(ir_write_en), 32'(e.irw));
            check_output("pc_write_en", 32'(pc_write_en), 32'(e.pcw));
            check_output("active", 32'(active), 32'(e.act));
        end
        check_output("strobe_exclusive", 32'(ir_write_en & pc_write_en), 32'h0);
        if (pc_write_en) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_retire: got pc_write_en=1 expected 0 (cycle %0d)", cyc);
            end else begin
                r = rq.pop_front();
                check_output("retire_cycle", 32'(cyc), 32'(r.at));
                check_output("retire_instr", instr, r.ins);
                check_output("retire_mem_data", mem_data, r.md);
                check_output("retire_count", 32'(instr_count), 32'(r.cnt));
            end
        end
    end

    initial begin
        logic [5:0]  op;
        logic [5:0]  st_ops [3];
        logic [5:0]  alu_ops [6];
        int          cls;
        st_ops  = '{6'd40, 6'd41, 6'd43};
        alu_ops = '{6'd0, 6'd2, 6'd8, 6'd9, 6'd13, 6'd15};
        m_mem = 32'h0; m_cnt = '0; m_instr = 32'h0;

        #12;
        check_output("reset_state", 32'(state), 32'h0);
        check_output("reset_instr", instr, 32'h0);
        check_output("reset_mem_data", mem_data, 32'h0);
        check_output("reset_active", 32'(active), 32'h1);
        check_output("reset_count", 32'(instr_count), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        apply_stimulus(32'h2408_0005, 0, 0, 0, $urandom, 32'h0000_0004);
        check_output("addiu_count", 32'(instr_count), 32'h1);
        apply_stimulus(32'h3C01_1234, 3, 0, 0, $urandom, 32'h0000_0008);
        apply_stimulus(32'h8C09_0000, 0, 2, 0, 32'hDEAD_BEEF, 32'h0000_000C);
        check_output("lw_mem_data", mem_data, 32'hDEAD_BEEF);
        apply_stimulus(32'hAC09_0004, 0, 3, 0, $urandom, 32'h0000_0010);
        check_output("sw_mem_data_hold", mem_data, 32'hDEAD_BEEF);
        apply_stimulus(32'h0109_0018, 0, 0, 5, $urandom, 32'h0000_0014);

        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 2);
            if (cls == 0)      op = 6'($urandom_range(32, 38));
            else if (cls == 1) op = st_ops[$urandom_range(0, 2)];
            else               op = alu_ops[$urandom_range(0, 5)];
            apply_stimulus({op, 26'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom, $urandom | 32'h0000_0004);
        end

        apply_stimulus(32'h03E0_0008, $urandom_range(0, 2), 0, $urandom_range(0, 2), $urandom, 32'h0);
        for (int i = 0; i < 20; i++)
            drive(rbit(), $urandom, rbit(), $urandom, 3'd4, 1'b0, 1'b0, 1'b0);
        check_output("halt_instr", instr, m_instr);
        check_output("halt_mem_data", mem_data, m_mem);
        check_output("halt_count", 32'(instr_count), 32'(m_cnt));
        check_output("retires_drained", 32'(rq.size()), 32'h0);

        reset = 1'b0;
        #1;
        check_output("halt_reset_state", 32'(state), 32'h0);
        check_output("halt_reset_active", 32'(active), 32'h1);
        @(posedge clk);
        #1 reset = 1'b1;
        m_mem = 32'h0; m_cnt = '0;

        apply_stimulus(32'h2408_0001, 0, 0, 0, $urandom, 32'h0000_0004);
        drive(1'b0, 32'h8C09_0000, 1'b0, 32'h4, 3'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, $urandom, 1'b0, 32'h4, 3'd1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, $urandom, 1'b0, 32'h4, 3'd2, 1'b0, 1'b0, 1'b1);
        check_output("pre_abort_count", 32'(instr_count), 32'h1);
        #2 reset = 1'b0;
        #1;
        check_output("abort_state", 32'(state), 32'h0);
        check_output("abort_instr", instr, 32'h0);
        check_output("abort_mem_data", mem_data, 32'h0);
        check_output("abort_count", 32'(instr_count), 32'h0);
        check_output("abort_pc_write_en", 32'(pc_write_en), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_output("abort_hold_state", 32'(state), 32'h0);
        check_output("final_retires_drained", 32'(rq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_state_sequencer.md
Name: cpu_state_sequencer

Overview:
Multicycle state sequencer for the bus-based MIPS core. It drives the 3-bit `state` code consumed by the control block and the instruction register (IR) that supplies opcode, function code and b-code. It also latches load data and gates PC updates. Stalls follow Avalon `waitrequest` and a busy flag from the multiply/divide unit. Halt is detected when the next PC equals the halt address.

Parameters:
HALT_ADDR, 32'h0000_0000, next-PC value that terminates execution.
COUNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
waitrequest  input  1  bus stall from memory
readdata  input  32  bus read data
pc_next  input  32  PC value selected for the next instruction
multdiv_busy  input  1  mult/div unit still computing
state  output  3  0=FETCH, 1=LOAD(decode), 2=MEM, 3=EXEC, 4=HALT
instr  output  32  instruction register
mem_data  output  32  latched load data
ir_write_en  output  1  IR capture strobe (combinational)
pc_write_en  output  1  PC update strobe (combinational)
active  output  1  high while CPU running
instr_count  output  COUNT_W  retired instructions

Behaviour:
- Reset (`reset`=0, asynchronous) forces:
  - state=FETCH, instr=0, mem_data=0, active=1, instr_count=0.
  - Outputs hold these values until the first rising edge after `reset` returns to 1.
- Reset asserted mid-operation aborts the current instruction immediately. There is no PC write and no count increment.
- opcode=instr[31:26].
- mem_op: opcode in {32..38} (load) or {40,41,43} (store). is_load: opcode in {32..38}.
- FETCH:
  - waitrequest=1: stay in FETCH; instr holds.
  - waitrequest=0: ir_write_en=1, instr<=readdata, next state LOAD.
- LOAD: one cycle unconditionally, then MEM. instr is stable from this state until the next FETCH capture.
- MEM:
  - If mem_op and waitrequest=1: stay in MEM.
  - Else, if is_load: mem_data<=readdata. mem_data holds for non-loads and stores.
  - Then next state EXEC. Non-memory instructions spend exactly one cycle in MEM.
- EXEC:
  - If multdiv_busy=1: stay in EXEC, pc_write_en=0.
  - Else: pc_write_en=1 for one cycle and instr_count<=instr_count+1 (wraps modulo 2^COUNT_W).
    - pc_next==HALT_ADDR: next state HALT.
    - Otherwise: next state FETCH.
- HALT:
  - Absorbing state; active=0 from the first cycle in HALT.
  - All strobes 0; instr, mem_data and instr_count frozen.
  - Only reset leaves HALT.
- ir_write_en and pc_write_en are never both 1 in the same cycle.
- Illegal state codes 5–7 recover to FETCH on the next edge.
- Latency (no stalls): 4 cycles per instruction. Each waitrequest or busy cycle adds exactly 1 cycle.
- waitrequest is ignored in LOAD, in EXEC, and in MEM for non-mem_op.
- multdiv_busy is ignored outside EXEC.

Test Plan:
- Reset release, readdata=0x2408_0005 (ADDIU), waitrequest=0, pc_next=0x4: states 0,1,2,3,0; instr=0x2408_0005 after cycle 1; pc_write_en pulses in cycle 4; instr_count=1.
- FETCH with waitrequest high for 3 cycles: state stays 0 for 4 cycles; IR captured only on the cycle waitrequest=0; total instruction latency 7 cycles.
- LW (0x8C09_0000), MEM waitrequest high 2 cycles, readdata=0xDEAD_BEEF on release: mem_data=0xDEAD_BEEF; EXEC entered after 3 MEM cycles. SW with waitrequest high: MEM held, mem_data unchanged.
- MULT (0x0109_0018), multdiv_busy high 5 cycles in EXEC: state stays 3 for 6 cycles; single pc_write_en pulse; instr_count increments once.
- JR to 0 (pc_next=0x0 at EXEC completion): state 4 next cycle, active=0; further readdata/waitrequest activity changes nothing for 20 cycles; reset low returns state=0, active=1.
- Reset asserted asynchronously mid-MEM of a load: state=0, instr=0, mem_data=0, instr_count=0 immediately, no pc_write_en pulse; instr_count preloaded near 2^COUNT_W-1 wraps to 0 after one retire.
